// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NCH independent programmable clock dividers from one clock.
// Each channel has its own period / high time, a run enable, and shadow
// registers that are applied only at a period boundary (or at once while the
// channel is disabled), so a reprogramming never produces a runt or a
// stretched pulse.
//
// Optional feature: define CLKDIV_SYNC_EN to make sync_i a global restart that
// phase-aligns all enabled channels. Without it sync_i is accepted and ignored.
//
// Ports:
//   clk          system clock, all flops on posedge
//   rst_n        asynchronous active-low reset
//   ch_en_i      per-channel run enable
//   wr_en_i      write strobe for one channel's shadow period/high time
//   wr_ch_i      target channel of the write (>= NCH is ignored)
//   wr_period_i  new period P (0 and 1 behave as 2)
//   wr_high_i    new high time H (0: constant low, >= P: constant high)
//   sync_i       global restart (CLKDIV_SYNC_EN only)
//   clk_out_o    registered divided outputs
//   tick_o       registered one-cycle pulse at the start of each period
//   upd_pend_o   shadow value waiting to be applied
module clk_divider_multi #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CW         = 16,
    parameter int unsigned DEF_PERIOD = 10,
    parameter int unsigned DEF_HIGH   = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] ch_en_i,
    input  logic           wr_en_i,
    input  logic [3:0]     wr_ch_i,
    input  logic [CW-1:0]  wr_period_i,
    input  logic [CW-1:0]  wr_high_i,
    input  logic           sync_i,
    output logic [NCH-1:0] clk_out_o,
    output logic [NCH-1:0] tick_o,
    output logic [NCH-1:0] upd_pend_o
);

    localparam int unsigned CHW = 4;
    localparam logic [CW-1:0] RST_PERIOD = CW'(DEF_PERIOD);
    localparam logic [CW-1:0] RST_HIGH   = CW'(DEF_HIGH);
    localparam logic [CW-1:0] RST_CNT    = CW'(DEF_PERIOD - 1);

    // Per-channel state
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [CW-1:0]  p_act_q [NCH];
    logic [CW-1:0]  p_act_d [NCH];
    logic [CW-1:0]  h_act_q [NCH];
    logic [CW-1:0]  h_act_d [NCH];
    logic [CW-1:0]  p_shd_q [NCH];
    logic [CW-1:0]  p_shd_d [NCH];
    logic [CW-1:0]  h_shd_q [NCH];
    logic [CW-1:0]  h_shd_d [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] clk_out_q;
    logic [NCH-1:0] clk_out_d;
    logic [NCH-1:0] tick_q;
    logic [NCH-1:0] tick_d;
    logic [NCH-1:0] wrap;

`ifdef CLKDIV_SYNC_EN
    logic sync_act;
    assign sync_act = sync_i;
`else
    logic unused_sync;
    assign unused_sync = sync_i;
`endif

    // Programmed periods below 2 run as 2
    function automatic logic [CW-1:0] eff_period(input logic [CW-1:0] p);
        return (p < CW'(2)) ? CW'(2) : p;
    endfunction

    // Next-state: count/wrap, shadow apply, registered output decode
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]     = cnt_q[i];
            p_act_d[i]   = p_act_q[i];
            h_act_d[i]   = h_act_q[i];
            p_shd_d[i]   = p_shd_q[i];
            h_shd_d[i]   = h_shd_q[i];
            pend_d[i]    = pend_q[i];
            clk_out_d[i] = 1'b0;
            tick_d[i]    = 1'b0;
            wrap[i]      = 1'b0;

            if (!ch_en_i[i]) begin
                // Parked one short of the wrap so re-enable starts a fresh period
                if (pend_q[i]) begin
                    p_act_d[i] = p_shd_q[i];
                    h_act_d[i] = h_shd_q[i];
                    pend_d[i]  = 1'b0;
                end
                cnt_d[i] = eff_period(p_act_d[i]) - CW'(1);
            end else begin
                wrap[i] = (cnt_q[i] >= eff_period(p_act_q[i]) - CW'(1));
`ifdef CLKDIV_SYNC_EN
                // Restart behaves exactly like a wrap, regardless of phase
                if (sync_act) begin
                    wrap[i] = 1'b1;
                end
`endif
                if (wrap[i]) begin
                    cnt_d[i] = '0;
                    if (pend_q[i]) begin
                        p_act_d[i] = p_shd_q[i];
                        h_act_d[i] = h_shd_q[i];
                        pend_d[i]  = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
                clk_out_d[i] = (cnt_d[i] < h_act_d[i]);
                tick_d[i]    = (cnt_d[i] == '0);
            end

            // A write always lands in the shadow; an apply this edge used the old one
            if (wr_en_i && (wr_ch_i == CHW'(i))) begin
                p_shd_d[i] = wr_period_i;
                h_shd_d[i] = wr_high_i;
                pend_d[i]  = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= RST_CNT;
                p_act_q[i] <= RST_PERIOD;
                h_act_q[i] <= RST_HIGH;
                p_shd_q[i] <= RST_PERIOD;
                h_shd_q[i] <= RST_HIGH;
            end
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                p_act_q[i] <= p_act_d[i];
                h_act_q[i] <= h_act_d[i];
                p_shd_q[i] <= p_shd_d[i];
                h_shd_q[i] <= h_shd_d[i];
            end
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o  = clk_out_q;
    assign tick_o     = tick_q;
    assign upd_pend_o = pend_q;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi (NCH=4, CW=16, defaults P=10 H=5).
module tb_clk_divider_multi;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [NCH-1:0] ch_en = '0;
    logic           wr_en = 1'b0;
    logic [3:0]     wr_ch = '0;
    logic [CW-1:0]  wr_period = '0;
    logic [CW-1:0]  wr_high = '0;
    logic           sync = 1'b0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] upd_pend;

    int checks = 0;
    int errors = 0;

    clk_divider_multi #(
        .NCH(NCH), .CW(CW), .DEF_PERIOD(10), .DEF_HIGH(5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_en_i    (ch_en),
        .wr_en_i    (wr_en),
        .wr_ch_i    (wr_ch),
        .wr_period_i(wr_period),
        .wr_high_i  (wr_high),
        .sync_i     (sync),
        .clk_out_o  (clk_out),
        .tick_o     (tick),
        .upd_pend_o (upd_pend)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel ch is k clocks into a run of period p, high time h
    task automatic expect_ch(input int ch, input int p, input int h, input int k);
        int c;
        c = k % p;
        chk($sformatf("tick%0d_k%0d", ch, k), 32'(tick[ch]), 32'(c == 0));
        chk($sformatf("clk_out%0d_k%0d", ch, k), 32'(clk_out[ch]), 32'(c < h));
    endtask

    task automatic write(input int ch, input int p, input int h);
        wr_en     = 1'b1;
        wr_ch     = 4'(ch);
        wr_period = CW'(p);
        wr_high   = CW'(h);
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        #2;
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_upd_pend", 32'(upd_pend), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_clk_out", 32'(clk_out), 32'h0);
        chk("idle_tick", 32'(tick), 32'h0);

        // Defaults on ch0 and ch1: first tick one edge after enable
        ch_en = 4'b0011;
        for (int k = 0; k <= 22; k++) begin
            step();
            expect_ch(0, 10, 5, k);
            expect_ch(1, 10, 5, k);
        end

        // Mid-period write ch1 P=4 H=1: current period finishes at 10
        write(1, 4, 1);
        step();
        wr_en = 1'b0;
        expect_ch(1, 10, 5, 23);
        chk("pend_after_wr1", 32'(upd_pend), 32'h2);
        for (int k = 24; k <= 29; k++) begin
            step();
            expect_ch(1, 10, 5, k);
        end
        chk("pend_before_wrap1", 32'(upd_pend), 32'h2);
        step();
        expect_ch(1, 4, 1, 0);
        chk("pend_clear_wrap1", 32'(upd_pend), 32'h0);
        for (int k = 1; k <= 11; k++) begin
            step();
            expect_ch(1, 4, 1, k);
        end

        // Boundary values written while disabled apply at once
        write(2, 1, 0);
        step();
        chk("pend_ch2_disabled", 32'(upd_pend), 32'h4);
        chk("dis_clk_out_hi", 32'(clk_out[3:2]), 32'h0);
        chk("dis_tick_hi", 32'(tick[3:2]), 32'h0);
        write(3, 3, 7);
        step();
        chk("pend_ch3_disabled", 32'(upd_pend), 32'h8);
        write(4, 2, 2);
        step();
        wr_en = 1'b0;
        chk("pend_out_of_range", 32'(upd_pend), 32'h0);
        ch_en = 4'b1111;
        for (int k = 0; k <= 11; k++) begin
            step();
            expect_ch(2, 2, 0, k);
            expect_ch(3, 3, 7, k);
            expect_ch(1, 4, 1, 15 + k);
        end

        // Write on ch2 coinciding with its wrap: lands in shadow only
        write(2, 6, 3);
        step();
        wr_en = 1'b0;
        expect_ch(2, 2, 0, 12);
        chk("pend_wrap_wr_a", 32'(upd_pend), 32'h4);
        step();
        expect_ch(2, 2, 0, 13);
        step();
        expect_ch(2, 6, 3, 0);
        chk("pend_clear_p6", 32'(upd_pend), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step();
            expect_ch(2, 6, 3, k);
        end
        write(2, 8, 4);
        step();
        wr_en = 1'b0;
        expect_ch(2, 6, 3, 6);
        chk("pend_wrap_wr_b", 32'(upd_pend), 32'h4);
        for (int k = 7; k <= 11; k++) begin
            step();
            expect_ch(2, 6, 3, k);
        end
        step();
        expect_ch(2, 8, 4, 0);
        chk("pend_clear_p8", 32'(upd_pend), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            step();
            expect_ch(2, 8, 4, k);
        end

        // Disable ch0 mid-period, reprogram, re-enable
        ch_en = 4'b1110;
        step();
        chk("dis0_clk_out", 32'(clk_out[0]), 32'h0);
        chk("dis0_tick", 32'(tick[0]), 32'h0);
        write(0, 5, 2);
        step();
        wr_en = 1'b0;
        chk("dis0_pend_set", 32'(upd_pend), 32'h1);
        chk("dis0_clk_out_b", 32'(clk_out[0]), 32'h0);
        step();
        chk("dis0_pend_applied", 32'(upd_pend), 32'h0);
        chk("dis0_tick_b", 32'(tick[0]), 32'h0);
        step();
        chk("dis0_clk_out_c", 32'(clk_out[0]), 32'h0);
        ch_en = 4'b1111;
        for (int k = 0; k <= 14; k++) begin
            step();
            expect_ch(0, 5, 2, k);
        end

`ifdef CLKDIV_SYNC_EN
        // Sync realigns P=6 and P=9 channels
        write(1, 6, 3);
        step();
        write(3, 9, 4);
        step();
        wr_en = 1'b0;
        repeat (20) step();
        chk("sync_pre_pend", 32'(upd_pend), 32'h0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_tick_all", 32'(tick), 32'hf);
        expect_ch(1, 6, 3, 0);
        expect_ch(3, 9, 4, 0);
        for (int k = 1; k <= 36; k++) begin
            step();
            expect_ch(1, 6, 3, k);
            expect_ch(3, 9, 4, k);
        end
`else
        // sync has no effect in this build
        sync = 1'b1;
        for (int k = 15; k <= 19; k++) begin
            step();
            expect_ch(0, 5, 2, k);
        end
        sync = 1'b0;
`endif

        // Reset mid-period discards a pending shadow
        write(0, 3, 1);
        step();
        wr_en = 1'b0;
        chk("pre_rst_pend", 32'(upd_pend[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk_out", 32'(clk_out), 32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_pend", 32'(upd_pend), 32'h0);
        ch_en = 4'b0001;
        step();
        chk("held_rst_clk_out", 32'(clk_out), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            step();
            expect_ch(0, 10, 5, k);
        end
        chk("post_rst_pend", 32'(upd_pend), 32'h0);
        chk("post_rst_others_clk", 32'(clk_out[3:1]), 32'h0);
        chk("post_rst_others_tick", 32'(tick[3:1]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
